// File: rtl/exu_stage.sv
// exu_stage: execute stage computing ALU/compare/CSR/jump results into a registered LSU bus.
// Define EXU_SERIAL_SHIFT_EN to replace the barrel shifter with a 1-bit-per-cycle serial shifter.
module exu_stage #(
    parameter int ADU_EXU_BUS_WIDTH = 233,
    parameter int EXU_LSU_BUS_WIDTH = 192
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         adu_valid_i,
    input  logic [ADU_EXU_BUS_WIDTH-1:0] adu_exu_bus_i,
    output logic                         exu_ready_o,
    input  logic                         lsu_ready_i,
    output logic [EXU_LSU_BUS_WIDTH-1:0] exu_lsu_bus_o,
    output logic                         valid_o
);
    typedef enum logic [1:0] {IDLE, BUSY, FULL} state_t;
    state_t state;
    logic [ADU_EXU_BUS_WIDTH-1:0] src_bus;
    logic res_from_compare, compare_result, excp_flush, xret_flush, break_signal;
    logic [31:0] snpc, src1, src2, rs2_value;
    logic [5:0] alu_op;
    logic res_from_mem, res_from_csr, gr_we, csr_we, jmp_flag;
    logic [3:0] mem_re, mem_we;
    logic [4:0] rd;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_value;
    logic [31:0] add_res, logic_res, sra_res, shift_res, alu_comb, alu_result, wb_value, dnpc;
    logic [EXU_LSU_BUS_WIDTH-1:0] next_bus;
    logic accept;

    assign {res_from_compare, compare_result, excp_flush, xret_flush, break_signal,
            snpc, src1, src2, rs2_value, alu_op,
            res_from_mem, res_from_csr, gr_we, csr_we, mem_re, mem_we, rd, jmp_flag,
            csr_addr, csr_wdata, csr_value} = src_bus;

    assign add_res   = alu_op[0] ? src1 - src2 : src1 + src2;
    assign logic_res = alu_op[3:0] == 4'b0110 ? src1 ^ src2 :
                       alu_op[3:0] == 4'b1110 ? src1 | src2 :
                       alu_op[3:0] == 4'b1000 ? src1 & src2 : '0;
    // Kept separate so the arithmetic shift is not made unsigned by the ternary below.
    assign sra_res   = $signed(src1) >>> src2[4:0];
    assign shift_res = !alu_op[0] ? src1 << src2[4:0] : alu_op[1] ? sra_res : src1 >> src2[4:0];
    assign alu_comb  = alu_op[5:4] == 2'b11 ? add_res :
                       alu_op[5:4] == 2'b01 ? logic_res :
                       alu_op[5:4] == 2'b10 ? shift_res : '0;

`ifdef EXU_SERIAL_SHIFT_EN
    logic [ADU_EXU_BUS_WIDTH-1:0] held;
    logic [31:0] sh_reg, sh_next;
    logic [4:0] cnt;
    logic serial;
    // While BUSY the captured instruction drives all fields; the shifter supplies alu_result.
    assign src_bus    = state == BUSY ? held : adu_exu_bus_i;
    assign sh_next    = !alu_op[0] ? sh_reg << 1 : alu_op[1] ? {sh_reg[31], sh_reg[31:1]} : {1'b0, sh_reg[31:1]};
    assign alu_result = state == BUSY ? sh_next : alu_comb;
    assign serial     = alu_op[5:4] == 2'b10 && src2[4:0] != 5'd0;
`else
    assign src_bus    = adu_exu_bus_i;
    assign alu_result = alu_comb;
`endif

    assign wb_value = res_from_compare ? {31'b0, compare_result} :
                      res_from_csr     ? csr_value :
                      jmp_flag         ? snpc : alu_result;
    assign dnpc     = jmp_flag ? alu_result : snpc;
    assign next_bus = {alu_result, wb_value, rs2_value, dnpc,
                       mem_re, mem_we, res_from_mem, gr_we, rd, csr_we, csr_addr, csr_wdata,
                       excp_flush, xret_flush, break_signal, jmp_flag};

    assign exu_ready_o = state == IDLE || (state == FULL && lsu_ready_i);
    assign accept      = adu_valid_i && exu_ready_o;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            valid_o       <= 1'b0;
            exu_lsu_bus_o <= '0;
`ifdef EXU_SERIAL_SHIFT_EN
            held          <= '0;
            sh_reg        <= '0;
            cnt           <= '0;
`endif
        end else if (accept) begin
`ifdef EXU_SERIAL_SHIFT_EN
            if (serial) begin
                state   <= BUSY;
                valid_o <= 1'b0;
                held    <= adu_exu_bus_i;
                sh_reg  <= src1;
                cnt     <= src2[4:0];
            end else begin
                state         <= FULL;
                valid_o       <= 1'b1;
                exu_lsu_bus_o <= next_bus;
            end
`else
            state         <= FULL;
            valid_o       <= 1'b1;
            exu_lsu_bus_o <= next_bus;
`endif
        end else if (state == FULL && lsu_ready_i) begin
            state   <= IDLE;
            valid_o <= 1'b0;
        end
`ifdef EXU_SERIAL_SHIFT_EN
        else if (state == BUSY) begin
            sh_reg <= sh_next;
            cnt    <= cnt - 5'd1;
            if (cnt == 5'd1) begin
                state         <= FULL;
                valid_o       <= 1'b1;
                exu_lsu_bus_o <= next_bus;
            end
        end
`endif
    end
endmodule

// File: tb/tb_exu_stage.sv
// tb_exu_stage: table-driven check of exu_stage results plus reset, backpressure and serial-shift sequences.
module tb_exu_stage;
    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         adu_valid_i = 1'b0;
    logic [232:0] adu_exu_bus_i = '0;
    logic         exu_ready_o;
    logic         lsu_ready_i = 1'b0;
    logic [191:0] exu_lsu_bus_o;
    logic         valid_o;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [232:0] bus;
        logic [31:0]  alu;
        logic [31:0]  wb;
        logic [31:0]  dnpc;
    } vec_t;
    vec_t tv[18];

    exu_stage dut (
        .clock(clock), .reset(reset), .adu_valid_i(adu_valid_i), .adu_exu_bus_i(adu_exu_bus_i),
        .exu_ready_o(exu_ready_o), .lsu_ready_i(lsu_ready_i), .exu_lsu_bus_o(exu_lsu_bus_o), .valid_o(valid_o)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [232:0] mkin(input logic rfc, cr, rfcsr, jmp, input logic [5:0] op,
                                          input logic [31:0] s1, s2, snpc, csrv, input int k);
        logic [7:0] m;
        m = k[7:0];
        return {rfc, cr, m[0], m[1], m[2], snpc, s1, s2, 32'hC0DE0000 | k, op,
                m[3], rfcsr, m[4], m[5], m[3:0], ~m[3:0], m[4:0] + 5'd1, jmp,
                12'h300 + 12'(k), 32'hCAFE0000 | k, csrv};
    endfunction

    function automatic logic [191:0] mkexp(input logic [232:0] b, input logic [31:0] alu, wb, dnpc);
        return {alu, wb, b[131:100], dnpc, b[89:86], b[85:82], b[93], b[91], b[81:77], b[90],
                b[75:64], b[63:32], b[230], b[229], b[228], b[76]};
    endfunction

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input int idx);
        int n, lat;
        logic [5:0] op;
        logic [4:0] amt;
        op  = tv[idx].bus[99:94];
        amt = tv[idx].bus[136:132];
        lat = 0;
`ifdef EXU_SERIAL_SHIFT_EN
        if (op[5:4] == 2'b10 && amt != 5'd0) lat = int'(amt);
`endif
        @(negedge clock);
        adu_valid_i = 1'b1;
        adu_exu_bus_i = tv[idx].bus;
        lsu_ready_i = 1'b0;
        check($sformatf("vec%0d ready", idx), 192'(exu_ready_o), 192'd1);
        @(posedge clock);
        #1 adu_valid_i = 1'b0;
        n = 0;
        while (!valid_o && n < 40) begin
            @(posedge clock);
            #1 n++;
        end
        check($sformatf("vec%0d latency", idx), 192'(n), 192'(lat));
        check($sformatf("vec%0d bus", idx), exu_lsu_bus_o, mkexp(tv[idx].bus, tv[idx].alu, tv[idx].wb, tv[idx].dnpc));
        lsu_ready_i = 1'b1;
        @(posedge clock);
        #1 lsu_ready_i = 1'b0;
        check($sformatf("vec%0d drained", idx), 192'(valid_o), 192'd0);
    endtask

    initial begin
        tv[0]  = '{mkin(0,0,0,0,6'b110001,32'd5,32'd7,32'h100,32'h0,1), 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h100};
        tv[1]  = '{mkin(0,0,0,0,6'b110000,32'hFFFFFFFF,32'd1,32'h104,32'h0,2), 32'h0, 32'h0, 32'h104};
        tv[2]  = '{mkin(0,0,0,1,6'b110000,32'h80000000,32'h10,32'h80000004,32'h0,3), 32'h80000010, 32'h80000004, 32'h80000010};
        tv[3]  = '{mkin(1,1,1,0,6'b110000,32'd1,32'd2,32'h200,32'hABCD,4), 32'd3, 32'd1, 32'h200};
        tv[4]  = '{mkin(0,1,1,0,6'b110000,32'd1,32'd2,32'h204,32'hABCD,5), 32'd3, 32'hABCD, 32'h204};
        tv[5]  = '{mkin(0,0,0,0,6'b010110,32'hF0F0F0F0,32'h0FF00FF0,32'h208,32'h0,6), 32'hFF00FF00, 32'hFF00FF00, 32'h208};
        tv[6]  = '{mkin(0,0,0,0,6'b011110,32'h12340000,32'h00005678,32'h20C,32'h0,7), 32'h12345678, 32'h12345678, 32'h20C};
        tv[7]  = '{mkin(0,0,0,0,6'b011000,32'hFFFF0000,32'h12345678,32'h210,32'h0,8), 32'h12340000, 32'h12340000, 32'h210};
        tv[8]  = '{mkin(0,0,0,0,6'b010001,32'hFFFFFFFF,32'hFFFFFFFF,32'h214,32'h0,9), 32'h0, 32'h0, 32'h214};
        tv[9]  = '{mkin(0,0,0,0,6'b100000,32'd1,32'd31,32'h218,32'h0,10), 32'h80000000, 32'h80000000, 32'h218};
        tv[10] = '{mkin(0,0,0,0,6'b100001,32'h80000000,32'd4,32'h21C,32'h0,11), 32'h08000000, 32'h08000000, 32'h21C};
        tv[11] = '{mkin(0,0,0,0,6'b100011,32'h80000000,32'd4,32'h220,32'h0,12), 32'hF8000000, 32'hF8000000, 32'h220};
        tv[12] = '{mkin(0,0,0,0,6'b100011,32'h80000001,32'h20,32'h224,32'h0,13), 32'h80000001, 32'h80000001, 32'h224};
        tv[13] = '{mkin(0,0,0,0,6'b000000,32'd9,32'd9,32'h228,32'h0,14), 32'h0, 32'h0, 32'h228};
        tv[14] = '{mkin(0,0,0,0,6'b110011,32'd0,32'd1,32'h22C,32'h0,15), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h22C};
        tv[15] = '{mkin(0,0,0,0,6'b100011,32'h7FFFFFFF,32'd8,32'h230,32'h0,16), 32'h007FFFFF, 32'h007FFFFF, 32'h230};
        tv[16] = '{mkin(0,0,0,0,6'b100101,32'hFFFFFFFF,32'd31,32'h234,32'h0,17), 32'h1, 32'h1, 32'h234};
        tv[17] = '{mkin(1,0,0,1,6'b110000,32'h1000,32'd4,32'h2000,32'h0,63), 32'h1004, 32'h0, 32'h1004};

        // Reset held with a valid request present: nothing may be captured.
        adu_valid_i = 1'b1;
        adu_exu_bus_i = tv[0].bus;
        lsu_ready_i = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("reset valid", 192'(valid_o), 192'd0);
        check("reset bus", exu_lsu_bus_o, 192'd0);
        check("reset ready", 192'(exu_ready_o), 192'd1);
        @(negedge clock) reset = 1'b1;
        @(posedge clock);
        #1 adu_valid_i = 1'b0;
        check("first accept valid", 192'(valid_o), 192'd1);
        check("first accept bus", exu_lsu_bus_o, mkexp(tv[0].bus, tv[0].alu, tv[0].wb, tv[0].dnpc));
        @(posedge clock);
        #1 lsu_ready_i = 1'b0;
        check("first drained", 192'(valid_o), 192'd0);

        for (int i = 0; i < 18; i++) apply(i);

        // Backpressure: A held for 3 stalled cycles, B captured when lsu_ready_i rises.
        @(negedge clock);
        adu_valid_i = 1'b1;
        adu_exu_bus_i = tv[5].bus;
        @(posedge clock);
        #1 adu_exu_bus_i = tv[6].bus;
        check("bp A valid", 192'(valid_o), 192'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("bp stall%0d ready", i), 192'(exu_ready_o), 192'd0);
            @(posedge clock);
            #1 check($sformatf("bp stall%0d bus", i), exu_lsu_bus_o, mkexp(tv[5].bus, tv[5].alu, tv[5].wb, tv[5].dnpc));
        end
        @(negedge clock) lsu_ready_i = 1'b1;
        #1 check("bp ready follows lsu", 192'(exu_ready_o), 192'd1);
        @(posedge clock);
        #1 adu_valid_i = 1'b0;
        check("bp B bus", exu_lsu_bus_o, mkexp(tv[6].bus, tv[6].alu, tv[6].wb, tv[6].dnpc));
        check("bp B valid", 192'(valid_o), 192'd1);
        @(posedge clock);
        #1 lsu_ready_i = 1'b0;
        check("bp no duplicate", 192'(valid_o), 192'd0);

`ifdef EXU_SERIAL_SHIFT_EN
        // Serial sra by 4: busy for 4 edges, then the result appears.
        @(negedge clock);
        adu_valid_i = 1'b1;
        adu_exu_bus_i = tv[11].bus;
        @(posedge clock);
        #1 adu_valid_i = 1'b0;
        for (int i = 1; i < 4; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("serial busy%0d valid", i), 192'(valid_o), 192'd0);
            check($sformatf("serial busy%0d ready", i), 192'(exu_ready_o), 192'd0);
        end
        @(posedge clock);
        #1 check("serial result", exu_lsu_bus_o, mkexp(tv[11].bus, tv[11].alu, tv[11].wb, tv[11].dnpc));
        lsu_ready_i = 1'b1;
        @(posedge clock);
        #1 lsu_ready_i = 1'b0;
        // Reset two edges into a shift discards the instruction.
        @(negedge clock);
        adu_valid_i = 1'b1;
        adu_exu_bus_i = tv[11].bus;
        @(posedge clock);
        #1 adu_valid_i = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        #1 check("midshift reset ready", 192'(exu_ready_o), 192'd1);
        @(negedge clock) reset = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            repeat (8) begin
                @(posedge clock);
                #1 seen |= valid_o;
            end
            check("midshift reset no valid", 192'(seen), 192'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/exu_stage.md
Name: exu_stage

Overview:
- Execute stage of the in-order NPC pipeline. It is the consumer end of the decode-to-execute bus.
- Accepts one decoded, operand-resolved instruction per handshake from the decode stage and computes the ALU / compare / CSR / jump result.
- Registers a packed result bus toward the load-store stage, with valid/ready backpressure on both sides.

Parameters:
- ADU_EXU_BUS_WIDTH, 233, width of the incoming decode bus; layout fixed below.
- EXU_LSU_BUS_WIDTH, 192, width of the outgoing result bus; layout fixed below.

Ports:
- clock  in  1  single clock; rising edge.
- reset  in  1  asynchronous, active-low reset.
- adu_valid_i  in  1  decode bus holds an instruction.
- adu_exu_bus_i  in  ADU_EXU_BUS_WIDTH  decoded instruction bus.
- exu_ready_o  out  1  stage can accept an instruction this cycle.
- lsu_ready_i  in  1  downstream accepts valid_o this cycle.
- exu_lsu_bus_o  out  EXU_LSU_BUS_WIDTH  registered result bus.
- valid_o  out  1  exu_lsu_bus_o holds a valid instruction.

Behaviour:
- Input bus layout, MSB to LSB:
  - res_from_compare1, compare_result1, excp_flush1, xret_flush1, break_signal1
  - snpc32, src1 32, src2 32, rs2_value32, alu_op6
  - res_from_mem1, res_from_csr1, gr_we1, csr_we1, mem_re4, mem_we4, rd5, jmp_flag1
  - csr_addr12, csr_wdata32, csr_value32
- Output bus layout, MSB to LSB:
  - alu_result32, wb_value32, mem_wdata32, dnpc32
  - mem_re4, mem_we4, res_from_mem1, gr_we1, rd5, csr_we1, csr_addr12, csr_wdata32
  - excp_flush1, xret_flush1, break_signal1, jmp_flag1
- alu_op decode:
  - [5:4]=11: adder. [0]=1 means src1-src2, else src1+src2.
  - [5:4]=01: logic on [3:0]. 0110 xor, 1110 or, 1000 and.
  - [5:4]=10: shifter, amount src2[4:0]. [0]=0 sll. [1:0]=01 srl. [1:0]=11 sra.
  - Any other encoding gives alu_result 0.
  - All arithmetic is 32-bit modulo; carries are dropped.
- Derived output fields:
  - wb_value priority: res_from_compare gives {31'b0,compare_result}; else res_from_csr gives csr_value; else jmp_flag gives snpc; else alu_result.
  - dnpc = jmp_flag ? alu_result : snpc.
  - mem_wdata = rs2_value.
  - All other fields pass through unchanged.
- States:
  - IDLE: empty. exu_ready_o=1.
  - BUSY: serial shift in progress; only entered with the optional feature. exu_ready_o=0.
  - FULL: result held, valid_o=1. exu_ready_o=lsu_ready_i.
- Transitions:
  - Accept = adu_valid_i & exu_ready_o.
  - IDLE with accept: go to FULL, or to BUSY per the optional feature.
  - FULL with lsu_ready_i and accept: stay FULL and load the new result (back-to-back, no bubble).
  - FULL with lsu_ready_i and no accept: go to IDLE.
  - FULL without lsu_ready_i: hold; the output bus stays stable.
- Latency: accept at edge N makes valid_o=1 after edge N. Throughput is 1 per cycle.
- Upstream rule: while exu_ready_o=0, upstream holds adu_valid_i and adu_exu_bus_i stable. The stage captures the bus only on accept.
- Reset:
  - While reset=0: state IDLE, valid_o=0, exu_lsu_bus_o=0, shift counter=0.
  - Inputs are ignored while reset=0.
  - Reset asserted mid-shift or in FULL discards the instruction.
- exu_ready_o is combinational from state and lsu_ready_i. It has no combinational path from adu_valid_i.

Optional Feature:
- Macro: EXU_SERIAL_SHIFT_EN.
- Defined:
  - A shift op with amount k>0 enters BUSY. It loads a 32-bit shift register and a 5-bit counter=k.
  - Each cycle the register shifts 1 bit (sra fills sign) and the counter decrements.
  - When the counter reaches 0, the stage goes to FULL. valid_o rises after edge N+k.
  - k=0 and non-shift ops behave as without the macro.
- Undefined:
  - Single-cycle barrel shifter; BUSY is unreachable; the counter is not instantiated.

Test Plan:
- Reset: hold reset=0 with adu_valid_i=1 -> valid_o=0, bus=0, exu_ready_o=1. Release reset -> first accept on next edge.
- Add/sub: alu_op=110001, src1=5, src2=7 -> alu_result=0xFFFFFFFE, wb_value=0xFFFFFFFE. alu_op=110000, src1=0xFFFFFFFF, src2=1 -> 0x00000000.
- Jump: jmp_flag=1, src1=0x80000000, src2=0x10, snpc=0x80000004 -> dnpc=0x80000010, wb_value=0x80000004.
- Backpressure: two back-to-back instructions with lsu_ready_i=0 for 3 cycles -> first result held stable, exu_ready_o=0, second captured the cycle lsu_ready_i=1, no loss or duplication.
- Compare/CSR priority: res_from_compare=1, compare_result=1, res_from_csr=1, csr_value=0xABCD -> wb_value=1. Compare cleared -> wb_value=0xABCD.
- Shift: sra src1=0x80000000, src2=4 -> alu_result=0xF8000000. With EXU_SERIAL_SHIFT_EN, valid_o rises 4 cycles after accept and exu_ready_o=0 meanwhile. Reset asserted at cycle 2 -> IDLE, valid_o never rises.
